// File: rtl/md5_seq_pkg.sv
// Shared widths, FSM state type and MD5 constant tables for the multi-block sequencer.
package md5_seq_pkg;

   localparam int BLK_W = 512;
   localparam int DIG_W = 128;

   typedef enum logic [2:0] {IDLE, LAUNCH, GAP, WAIT, DONE} seq_state_t;

   localparam logic [31:0] MD5_IV [4] = '{32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

   localparam logic [31:0] K_TAB [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

   // Rotate amount indexed by {round group, round[1:0]}.
   localparam logic [4:0] S_TAB [16] = '{
      5'd7, 5'd12, 5'd17, 5'd22, 5'd5, 5'd9, 5'd14, 5'd20,
      5'd4, 5'd11, 5'd16, 5'd23, 5'd6, 5'd10, 5'd15, 5'd21
   };

   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

endpackage

// File: rtl/md5_blk_buf.sv
// DEPTH x 512-bit block register file: one write port, one asynchronous read port.
module md5_blk_buf
   import md5_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
)
(
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [0:BLK_W-1] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [0:BLK_W-1] rd_data
);

   logic [0:BLK_W-1] slot_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) slot_q[wr_addr] <= wr_data;
   end

   assign rd_data = slot_q[rd_addr];

endmodule

// File: rtl/md5_core.sv
// Iterative MD5 compression core: one round per cycle, done rises 65 cycles after launch.
module md5_core
   import md5_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             core_start,
   input  logic             core_resume,
   input  logic [0:BLK_W-1] core_blk,
   output logic             core_done,
   output logic [0:DIG_W-1] core_out
);

   logic [31:0] a_q, b_q, c_q, d_q;
   logic [31:0] h0_q, h1_q, h2_q, h3_q;
   logic [31:0] m_q [16];
   logic [5:0]  rnd_q;
   logic        run_q, done_q;
   logic        launch;
   logic [31:0] f_d, sum_d, rot_d, b_d;
   logic [3:0]  g_d;
   logic [4:0]  s_d;

   assign launch = core_start | core_resume;

   always_comb begin
      f_d = '0;
      g_d = '0;
      case (rnd_q[5:4])
         2'd0: begin f_d = (b_q & c_q) | (~b_q & d_q); g_d = rnd_q[3:0]; end
         2'd1: begin f_d = (d_q & b_q) | (~d_q & c_q); g_d = rnd_q[3:0] * 4'd5 + 4'd1; end
         2'd2: begin f_d = b_q ^ c_q ^ d_q;            g_d = rnd_q[3:0] * 4'd3 + 4'd5; end
         default: begin f_d = c_q ^ (b_q | ~d_q);      g_d = rnd_q[3:0] * 4'd7; end
      endcase
      s_d   = S_TAB[{rnd_q[5:4], rnd_q[1:0]}];
      sum_d = a_q + f_d + K_TAB[rnd_q] + m_q[g_d];
      rot_d = (sum_d << s_d) | (sum_d >> (6'd32 - {1'b0, s_d}));
      b_d   = b_q + rot_d;
   end

   // Message words are little-endian within each 4-byte group of the block.
   always_ff @(posedge clk) begin
      if (launch) begin
         for (int j = 0; j < 16; j++) m_q[j] <= bswap32(core_blk[32*j +: 32]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
         h0_q <= '0; h1_q <= '0; h2_q <= '0; h3_q <= '0;
         rnd_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else if (launch) begin
         a_q <= core_start ? MD5_IV[0] : h0_q;
         b_q <= core_start ? MD5_IV[1] : h1_q;
         c_q <= core_start ? MD5_IV[2] : h2_q;
         d_q <= core_start ? MD5_IV[3] : h3_q;
         if (core_start) begin
            h0_q <= MD5_IV[0]; h1_q <= MD5_IV[1]; h2_q <= MD5_IV[2]; h3_q <= MD5_IV[3];
         end
         rnd_q  <= '0;
         run_q  <= 1'b1;
         done_q <= 1'b0;
      end else if (run_q) begin
         a_q   <= d_q;
         b_q   <= b_d;
         c_q   <= b_q;
         d_q   <= c_q;
         rnd_q <= rnd_q + 6'd1;
         if (rnd_q == 6'd63) begin
            run_q  <= 1'b0;
            done_q <= 1'b1;
            h0_q   <= h0_q + d_q;
            h1_q   <= h1_q + b_d;
            h2_q   <= h2_q + b_q;
            h3_q   <= h3_q + c_q;
         end
      end
   end

   assign core_done = done_q;
   assign core_out  = {bswap32(h0_q), bswap32(h1_q), bswap32(h2_q), bswap32(h3_q)};

endmodule

// File: rtl/md5_msg_sequencer.sv
// Multi-block MD5 message engine: chains slots 0..nblk-1 through one md5_core.
module md5_msg_sequencer
   import md5_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [0:BLK_W-1] wr_data,
   input  logic             msg_start,
   input  logic [AW:0]      msg_nblk,
   output logic             busy,
   output logic [0:DIG_W-1] digest,
   output logic             digest_valid,
   output logic             err
);

   localparam logic [AW:0] DEPTH_N = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_N   = (AW+1)'(1);

   seq_state_t       state_q;
   logic [AW:0]      nblk_q;
   logic [AW-1:0]    blk_idx_q;
   logic             busy_q, digest_valid_q, err_q;
   logic             core_start_q, core_resume_q;
   logic [0:DIG_W-1] digest_q;
   logic [0:BLK_W-1] blk_data;
   logic             core_done;
   logic [0:DIG_W-1] core_out;
   logic             req_legal;

   assign req_legal = (msg_nblk != '0) && (msg_nblk <= DEPTH_N);

   md5_blk_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
      .clk     (clk),
      .wr_en   (wr_en & ~busy_q),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (blk_idx_q),
      .rd_data (blk_data)
   );

   md5_core u_core (
      .clk         (clk),
      .rst_n       (rst_n),
      .core_start  (core_start_q),
      .core_resume (core_resume_q),
      .core_blk    (blk_data),
      .core_done   (core_done),
      .core_out    (core_out)
   );

   // core_start/core_resume are registered so they coincide with the LAUNCH cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         nblk_q         <= '0;
         blk_idx_q      <= '0;
         busy_q         <= 1'b0;
         digest_q       <= '0;
         digest_valid_q <= 1'b0;
         err_q          <= 1'b0;
         core_start_q   <= 1'b0;
         core_resume_q  <= 1'b0;
      end else begin
         digest_valid_q <= 1'b0;
         err_q          <= 1'b0;
         core_start_q   <= 1'b0;
         core_resume_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (msg_start) begin
                  if (req_legal) begin
                     state_q      <= LAUNCH;
                     nblk_q       <= msg_nblk;
                     blk_idx_q    <= '0;
                     busy_q       <= 1'b1;
                     core_start_q <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            LAUNCH: state_q <= GAP;
            GAP:    state_q <= WAIT;
            WAIT: begin
               if (core_done) begin
                  if (({1'b0, blk_idx_q} + ONE_N) < nblk_q) begin
                     blk_idx_q     <= blk_idx_q + AW'(1);
                     core_resume_q <= 1'b1;
                     state_q       <= LAUNCH;
                  end else begin
                     digest_q       <= core_out;
                     digest_valid_q <= 1'b1;
                     state_q        <= DONE;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy         = busy_q;
   assign digest       = digest_q;
   assign digest_valid = digest_valid_q;
   assign err          = err_q;

endmodule

// File: tb/tb_md5_msg_sequencer.sv
// Directed bench for md5_msg_sequencer: table of messages plus multi-cycle corner sequences.
module tb_md5_msg_sequencer;

   localparam int C = 65;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         wr_en;
   logic [1:0]   wr_addr;
   logic [0:511] wr_data;
   logic         msg_start;
   logic [2:0]   msg_nblk;
   logic         busy;
   logic [0:127] digest;
   logic         digest_valid;
   logic         err;

   int n_cmp = 0;
   int n_bad = 0;

   md5_msg_sequencer #(.DEPTH(4), .AW(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .msg_start    (msg_start),
      .msg_nblk     (msg_nblk),
      .busy         (busy),
      .digest       (digest),
      .digest_valid (digest_valid),
      .err          (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

   typedef struct packed {
      logic [0:511] s0;
      logic [0:511] s1;
      logic [2:0]   nblk;
      logic         exp_err;
      logic [0:127] exp_dig;
   } vec_t;

   vec_t vecs [5];

   logic [0:511] e0, a0, x0, x1, junk;
   logic [0:127] d_x100;
   localparam logic [0:127] D_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
   localparam logic [0:127] D_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;

   // ---------------- reference MD5 (RFC 1321 formulation, K from sine) ----------------
   function automatic logic [31:0] bs(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   function automatic logic [31:0] kval(input int i);
      real r;
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      return 32'(longint'($floor(r * 4294967296.0)));
   endfunction

   function automatic logic [0:127] md5_model(input logic [0:511] b0, input logic [0:511] b1, input int n);
      logic [31:0] h [4];
      logic [31:0] w [16];
      logic [31:0] a, b, c, d, f, t;
      logic [0:511] blk;
      int g, sh;
      int sh_tab [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
      h[0] = 32'h67452301; h[1] = 32'hefcdab89; h[2] = 32'h98badcfe; h[3] = 32'h10325476;
      for (int k = 0; k < n; k++) begin
         blk = (k == 0) ? b0 : b1;
         for (int j = 0; j < 16; j++)
            w[j] = {blk[32*j+24 +: 8], blk[32*j+16 +: 8], blk[32*j+8 +: 8], blk[32*j +: 8]};
         a = h[0]; b = h[1]; c = h[2]; d = h[3];
         for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
            sh = sh_tab[(i / 16) * 4 + (i % 4)];
            t = a + f + kval(i) + w[g];
            a = d; d = c; c = b;
            b = b + ((t << sh) | (t >> (32 - sh)));
         end
         h[0] = h[0] + a; h[1] = h[1] + b; h[2] = h[2] + c; h[3] = h[3] + d;
      end
      return {bs(h[0]), bs(h[1]), bs(h[2]), bs(h[3])};
   endfunction

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, got, exp);
      end
   endtask

   task automatic write_slot(input logic [1:0] adr, input logic [0:511] dat);
      wr_en = 1'b1; wr_addr = adr; wr_data = dat;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic start_msg(input logic [2:0] n);
      msg_start = 1'b1; msg_nblk = n;
      tick();
      msg_start = 1'b0;
   endtask

   // Entered in cycle `first`; returns in the digest_valid cycle (or after the budget).
   task automatic run_to_done(input int first, input int limit, output int vcyc, output int scyc, output int rcyc);
      int cur;
      cur = first; vcyc = -1; scyc = -1; rcyc = -1;
      while (cur <= limit) begin
         if (dut.core_start_q  && scyc < 0) scyc = cur;
         if (dut.core_resume_q && rcyc < 0) rcyc = cur;
         if (digest_valid) begin
            vcyc = cur;
            break;
         end
         tick();
         cur++;
      end
   endtask

   int vc, sc, rc;

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_start = 1'b0; msg_nblk = '0;

      e0 = '0; e0[0 +: 8] = 8'h80;
      a0 = '0; a0[0 +: 32] = 32'h61626380; a0[448 +: 8] = 8'h18;
      x0 = {64{8'h58}};
      x1 = '0;
      for (int i = 0; i < 36; i++) x1[8*i +: 8] = 8'h58;
      x1[288 +: 8]  = 8'h80;
      x1[448 +: 16] = 16'h2003;
      junk = {16{32'hdeadbeef}};
      d_x100 = md5_model(x0, x1, 2);

      vecs[0] = '{s0: e0, s1: '0, nblk: 3'd1, exp_err: 1'b0, exp_dig: D_EMPTY};
      vecs[1] = '{s0: a0, s1: '0, nblk: 3'd1, exp_err: 1'b0, exp_dig: D_ABC};
      vecs[2] = '{s0: x0, s1: x1, nblk: 3'd2, exp_err: 1'b0, exp_dig: d_x100};
      vecs[3] = '{s0: x0, s1: x1, nblk: 3'd0, exp_err: 1'b1, exp_dig: d_x100};
      vecs[4] = '{s0: x0, s1: x1, nblk: 3'd5, exp_err: 1'b1, exp_dig: d_x100};

      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_digest", digest, 0);
      chk("rst_dvalid", digest_valid, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 5; v++) begin
         write_slot(2'd0, vecs[v].s0);
         write_slot(2'd1, vecs[v].s1);
         start_msg(vecs[v].nblk);
         chk($sformatf("vec%0d_busy_c1", v), busy, !vecs[v].exp_err);
         chk($sformatf("vec%0d_err_c1", v), err, vecs[v].exp_err);
         if (vecs[v].exp_err) begin
            tick();
            chk($sformatf("vec%0d_err_c2", v), err, 0);
            chk($sformatf("vec%0d_busy_c2", v), busy, 0);
            chk($sformatf("vec%0d_digest_held", v), digest, vecs[v].exp_dig);
            vc = 1;
         end else begin
            run_to_done(1, 400, vc, sc, rc);
            chk($sformatf("vec%0d_valid_cycle", v), vc, int'(vecs[v].nblk) * (C + 1) + 1);
            chk($sformatf("vec%0d_digest", v), digest, vecs[v].exp_dig);
            chk($sformatf("vec%0d_busy_done", v), busy, 1);
            chk($sformatf("vec%0d_start_cycle", v), sc, 1);
            if (vecs[v].nblk == 3'd2) chk($sformatf("vec%0d_resume_cycle", v), rc, C + 2);
            tick();
            chk($sformatf("vec%0d_dvalid_drop", v), digest_valid, 0);
            chk($sformatf("vec%0d_busy_idle", v), busy, 0);
         end
         $display("vec%0d nblk=%0d err_exp=%0b cycle=%0d digest=%h", v, vecs[v].nblk, vecs[v].exp_err, vc, digest);
         tick();
      end

      // Start request and slot-1 write while busy are both ignored.
      start_msg(3'd2);
      repeat (9) tick();
      msg_start = 1'b1; msg_nblk = 3'd1;
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = junk;
      tick();
      msg_start = 1'b0; wr_en = 1'b0;
      chk("busy_start_err", err, 0);
      chk("busy_start_busy", busy, 1);
      run_to_done(11, 400, vc, sc, rc);
      chk("busy_run_cycle", vc, 2 * (C + 1) + 1);
      chk("busy_run_digest", digest, d_x100);
      $display("busy-interference run cycle=%0d digest=%h", vc, digest);
      repeat (2) tick();
      start_msg(3'd2);
      run_to_done(1, 400, vc, sc, rc);
      chk("rerun_digest", digest, d_x100);
      $display("rerun after dropped write cycle=%0d digest=%h", vc, digest);
      repeat (2) tick();

      // Reset asserted mid-message during WAIT.
      write_slot(2'd0, e0);
      start_msg(3'd1);
      repeat (19) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_digest", digest, 0);
      chk("midrst_dvalid", digest_valid, 0);
      chk("midrst_err", err, 0);
      tick();
      rst_n = 1'b1;
      tick();
      write_slot(2'd0, a0);
      start_msg(3'd1);
      run_to_done(1, 400, vc, sc, rc);
      chk("postrst_cycle", vc, C + 2);
      chk("postrst_digest", digest, D_ABC);
      $display("post-reset run cycle=%0d digest=%h", vc, digest);
      repeat (2) tick();

      // Start held through DONE (ignored) into the first IDLE cycle (accepted), with a same-cycle slot-0 write.
      write_slot(2'd0, e0);
      start_msg(3'd1);
      run_to_done(1, 400, vc, sc, rc);
      chk("b2b_first_digest", digest, D_EMPTY);
      msg_start = 1'b1; msg_nblk = 3'd1;
      tick();
      chk("b2b_done_ignored_busy", busy, 0);
      chk("b2b_done_ignored_err", err, 0);
      wr_en = 1'b1; wr_addr = 2'd0; wr_data = a0;
      tick();
      msg_start = 1'b0; wr_en = 1'b0;
      chk("b2b_idle_accepted", busy, 1);
      run_to_done(1, 400, vc, sc, rc);
      chk("b2b_second_cycle", vc, C + 2);
      chk("b2b_second_digest", digest, D_ABC);
      $display("back-to-back run cycle=%0d digest=%h", vc, digest);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/md5_msg_sequencer.md
# md5_msg_sequencer

Multi-block MD5 message engine. It wraps one `md5_core` with a runtime-loadable buffer of DEPTH 512-bit blocks. On `msg_start` it hashes the first `msg_nblk` blocks as one message, chaining them through the core's start/resume controls, then captures the 128-bit digest. It is the parametrised successor of the fixed two-block fmax harness and the block used for multi-block hashing and Fmax runs.

## Interface
Parameters:
- DEPTH, 4: number of 512-bit block slots in the buffer; must be at least 2.
- AW, $clog2(DEPTH): slot address width.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write `wr_data` into slot `wr_addr`; ignored while `busy`.
- wr_addr  in  AW  target slot.
- wr_data  in  [0:511]  pre-padded message block, MD5 byte order.
- msg_start  in  1  one-cycle request to hash slots 0..msg_nblk-1.
- msg_nblk  in  AW+1  block count, legal range 1..DEPTH; sampled with `msg_start`.
- busy  out  1  message in progress.
- digest  out  [0:127]  last completed digest; held until the next completion.
- digest_valid  out  1  one-cycle pulse when `digest` updates.
- err  out  1  one-cycle pulse when a `msg_start` is rejected.

## Operation
- Core contract:
  - `core_start` begins a block from the MD5 IV.
  - `core_resume` begins a block from the core's current chaining state.
  - The core samples its block input on the start/resume cycle.
  - `core_done` drops in the cycle after start/resume and rises C ≥ 2 cycles after the launch cycle, with `core_out` valid.
- The block input is `buf[blk_idx]`, driven combinationally from the slot register and stable for the whole message.
- FSM states:
  - IDLE, waiting for a request.
  - LAUNCH: `core_start` if `blk_idx`==0, else `core_resume`; one cycle.
  - GAP: one cycle; `core_done` is ignored.
  - WAIT: holds until `core_done`.
  - DONE: one cycle, pulses `digest_valid`.
- Transitions:
  - IDLE→LAUNCH on a legal `msg_start`; latch `nblk`, clear `blk_idx`, set `busy`.
  - LAUNCH→GAP unconditionally.
  - GAP→WAIT unconditionally.
  - WAIT with `core_done`:
    - if `blk_idx`+1 < `nblk`, increment `blk_idx` and go to LAUNCH;
    - otherwise load `digest` from `core_out` and go to DONE.
  - DONE→IDLE; clear `busy`.
- Illegal request: `msg_start` in IDLE with `msg_nblk`==0 or `msg_nblk`>DEPTH pulses `err` the next cycle and the FSM stays in IDLE.
- `msg_start` outside IDLE is ignored; no `err`.
- `wr_en` while `busy` is dropped; slot contents are unchanged.
- `wr_en` and `msg_start` in the same IDLE cycle: the write lands, and block 0 sees the new data if `wr_addr`==0.
- Rearm from DONE: `msg_start` asserted in DONE is ignored. A new message can be accepted in the first IDLE cycle.
- Reset mid-message: everything returns to reset values at once and the core is reset via `rst_n`. Slot contents are not reset and are undefined after power-up until written.

## Timing
- Reset values: `busy`=0, `digest`=0, `digest_valid`=0, `err`=0, state=IDLE, `blk_idx`=0.
- Cycle 0 is the cycle `msg_start` is sampled in IDLE.
  - `busy` is high from cycle 1 through the DONE cycle.
  - LAUNCH for block k occurs at cycle 1+k·(C+1).
  - `digest_valid` is high in cycle `nblk`·(C+1)+1.
- `err` is high in cycle 1 only.
- `digest` changes only on the edge entering DONE.

## Structure
- Package `md5_seq_pkg` holds:
  - `BLK_W`=512 and `DIG_W`=128;
  - the state enum `seq_state_t` {IDLE, LAUNCH, GAP, WAIT, DONE}.
- Sub-module `md5_blk_buf` (DEPTH×512 register file): one write port and one asynchronous read port.
- The top level holds the FSM, the counters and the `md5_core` instance.

## Test plan
- Empty message: write slot0 = 0x80 followed by 63 zero bytes; `msg_nblk`=1. Required: `digest`=d41d8cd98f00b204e9800998ecf8427e, `digest_valid` pulse in cycle C+2.
- "abc": slot0 = 0x616263 80, zero bytes, 0x18 at byte 56; `nblk`=1. Required: `digest`=900150983cd24fb0d6963f7d28e17f72.
- Two blocks, 100 × 0x58:
  - slot0 = 64 × 0x58;
  - slot1 = 36 × 0x58, 0x80, zero fill, length bytes 2003000000000000.
  - Required: LAUNCH uses `core_start` then `core_resume`, `digest_valid` in cycle 2C+3, and `digest` equals the golden-model MD5.
- Illegal and ignored requests:
  - `msg_nblk`=0 → `err` in cycle 1, `busy` stays 0;
  - `msg_nblk`=DEPTH+1 → same;
  - `msg_start` while `busy` → no effect.
- Writes while busy: writing slot1 during a two-block run is dropped; rerunning the same message gives an identical `digest`.
- Reset and back-to-back:
  - assert `rst_n`=0 during WAIT → all outputs 0 immediately, and the next message completes correctly;
  - `msg_start` in DONE → ignored; `msg_start` in the first IDLE cycle → accepted.
